jtcps_cfg_mmr: RTL

Parametrised, runtime-configurable register file for the CPS-B side of the video chipset. It generalises the fixed CPS-B register set to NREG relocatable 16-bit registers plus a sequential multiplier and ID read-back. All register addresses are loaded per game through the byte-wide configuration port. It sits between the 68000 bus decoder (CPS-B chip select) and the video/priority logic, and drives register contents and one-cycle write-event strobes.

---
 rtl/jtcps_cfg_mmr.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/jtcps_cfg_mmr.sv
// ============================================================================
// Module   : jtcps_cfg_mmr
// Function : CPS-B register file with per-game relocatable addresses,
//            shift-add multiplier and ID read-back.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jtcps_cfg_mmr #(
  parameter int              NREG   = 8,
  parameter int              AW     = 5,
  parameter int              MULW   = 16,
  parameter logic [NREG-1:0] EVMASK = '0
)(
  input  logic               clk,
  input  logic               reg_rst,
  input  logic               cs,
  input  logic               rnw,
  input  logic [AW:1]        addr,
  input  logic [1:0]         dsn,
  input  logic [15:0]        din,
  output logic [15:0]        dout,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_data,
  input  logic               cfg_rst,
  output logic               cfg_done,
  output logic [16*NREG-1:0] regs_out,
  output logic [NREG-1:0]    ev,
  output logic               mult_busy
);

  localparam int CFGLEN = NREG + 6;
  localparam int c_CW   = $clog2(CFGLEN + 1);
  localparam int c_NDEC = NREG + 5;            // decoded addresses (all but ID value)
  localparam int c_SW   = $clog2(c_NDEC + 1);
  localparam int c_MW   = $clog2(MULW);
  // priority-ordered select codes following the slots
  localparam logic [c_SW-1:0] c_SEL_ID = c_SW'(NREG);
  localparam logic [c_SW-1:0] c_SEL_M1 = c_SW'(NREG + 1);
  localparam logic [c_SW-1:0] c_SEL_M2 = c_SW'(NREG + 2);
  localparam logic [c_SW-1:0] c_SEL_R0 = c_SW'(NREG + 3);
  localparam logic [c_SW-1:0] c_SEL_R1 = c_SW'(NREG + 4);

  function automatic logic [AW-1:0] dec_addr(input logic [7:0] b);
    dec_addr = AW'(b >> 1);
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [1:0]  strb_n);
    lane_merge = {strb_n[1] ? old_v[15:8] : new_v[15:8],
                  strb_n[0] ? old_v[7:0]  : new_v[7:0]};
  endfunction

  // ---------------------------------------------------------------- config
  logic [7:0]      r_cfg [CFGLEN];
  logic            r_cfg_we_l;
  logic [c_CW-1:0] r_cfg_cnt;
  logic            w_cfg_edge;

  assign w_cfg_edge = cfg_we & ~r_cfg_we_l;
  assign cfg_done   = (r_cfg_cnt == c_CW'(CFGLEN));

  // Configuration survives reg_rst so a soft reset keeps the game mapping.
  always_ff @(posedge clk) begin
    if (w_cfg_edge) begin
      r_cfg[0] <= cfg_data;
      for (int k = 1; k < CFGLEN; k++) r_cfg[k] <= r_cfg[k-1];
    end
  end

  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst) begin
      r_cfg_we_l <= 1'b0;
      r_cfg_cnt  <= '0;
    end else begin
      r_cfg_we_l <= cfg_we;
      if (cfg_rst)
        r_cfg_cnt <= w_cfg_edge ? c_CW'(1) : '0;
      else if (w_cfg_edge && r_cfg_cnt != c_CW'(CFGLEN))
        r_cfg_cnt <= r_cfg_cnt + c_CW'(1);
    end
  end

  // ---------------------------------------------------------------- decode
  logic [c_NDEC-1:0] w_match;
  logic [c_NDEC-1:0] w_prio;
  logic              w_hit;
  logic [c_SW-1:0]   w_sel;

  for (genvar k = 0; k < c_NDEC; k++) begin : g_match
    assign w_match[k] = (addr == dec_addr(r_cfg[k])) && (dec_addr(r_cfg[k]) != '1);
  end

  // slots, ID, mult1, mult2, rslt0, rslt1 -- index 0 wins
  assign w_prio = {w_match[NREG+3:NREG], w_match[NREG+4], w_match[NREG-1:0]};

  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = c_NDEC - 1; i >= 0; i--) begin
      if (w_prio[i]) begin
        w_hit = 1'b1;
        w_sel = c_SW'(i);
      end
    end
  end

  // ---------------------------------------------------------------- bus
  logic             r_cs_l;
  logic [15:0]      r_regs [NREG];
  logic [15:0]      r_mult1, r_mult2;
  logic [15:0]      r_rslt0, r_rslt1;
  logic [15:0]      r_dout;
  logic [NREG-1:0]  r_pend, r_ev;
  logic             w_access, w_wr;
  logic [15:0]      w_rdata;
  logic [15:0]      w_new_m1, w_new_m2;
  logic             w_mul_start;
  logic [NREG-1:0]  w_evset;
  logic [7:0]       w_id;

  assign w_access = cs & ~r_cs_l;
  assign w_wr     = w_access & ~rnw & w_hit;
  assign w_id     = r_cfg[NREG+5];

  always_comb begin
    w_rdata = 16'hffff;
    if (w_hit) begin
      for (int k = 0; k < NREG; k++)
        if (w_sel == c_SW'(k)) w_rdata = r_regs[k];
      case (w_sel)
        c_SEL_ID: w_rdata = {4'd0, w_id[7:4], 4'd0, w_id[3:0]};
        c_SEL_M1: w_rdata = r_mult1;
        c_SEL_M2: w_rdata = r_mult2;
        c_SEL_R0: w_rdata = r_rslt0;
        c_SEL_R1: w_rdata = r_rslt1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_new_m1    = r_mult1;
    w_new_m2    = r_mult2;
    w_mul_start = 1'b0;
    w_evset     = '0;
    if (w_wr) begin
      if (w_sel == c_SEL_M1) begin
        w_new_m1    = lane_merge(r_mult1, din, dsn);
        w_mul_start = 1'b1;
      end
      if (w_sel == c_SEL_M2) begin
        w_new_m2    = lane_merge(r_mult2, din, dsn);
        w_mul_start = 1'b1;
      end
      for (int k = 0; k < NREG; k++)
        if (w_sel == c_SW'(k)) w_evset[k] = EVMASK[k];
    end
  end

  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst) begin
      r_cs_l  <= 1'b0;
      r_mult1 <= '0;
      r_mult2 <= '0;
      r_dout  <= 16'hffff;
      r_pend  <= '0;
      r_ev    <= '0;
      for (int k = 0; k < NREG; k++) r_regs[k] <= 16'hffff;
    end else begin
      r_cs_l  <= cs;
      r_mult1 <= w_new_m1;
      r_mult2 <= w_new_m2;
      if (w_access && rnw) r_dout <= w_rdata;
      for (int k = 0; k < NREG; k++)
        if (w_wr && w_sel == c_SW'(k)) r_regs[k] <= lane_merge(r_regs[k], din, dsn);
      // events wait for the bus to release so held cycles collapse into one pulse
      r_ev   <= cs ? '0 : r_pend;
      r_pend <= cs ? (r_pend | w_evset) : '0;
    end
  end

  assign dout = r_dout;
  assign ev   = r_ev;

  for (genvar k = 0; k < NREG; k++) begin : g_out
    assign regs_out[16*k +: 16] = r_regs[k];
  end

  // ---------------------------------------------------------------- multiplier
  logic                r_busy;
  logic [c_MW-1:0]     r_cnt;
  logic [2*MULW-1:0]   r_acc, r_mcand;
  logic [MULW-1:0]     r_mplier;
  logic [2*MULW-1:0]   w_acc_nx;
  logic [31:0]         w_prod;

  assign w_acc_nx  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod    = 32'(w_acc_nx);
  assign mult_busy = r_busy;

  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rslt0  <= '0;
      r_rslt1  <= '0;
    end else if (w_mul_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{MULW{1'b0}}, w_new_m1[MULW-1:0]};
      r_mplier <= w_new_m2[MULW-1:0];
    end else if (r_busy) begin
      r_acc    <= w_acc_nx;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + c_MW'(1);
      if (r_cnt == c_MW'(MULW - 1)) begin
        r_busy  <= 1'b0;
        r_rslt0 <= w_prod[15:0];
        r_rslt1 <= w_prod[31:16];
      end
    end
  end

endmodule

`default_nettype wire
